// File: rtl/dot_product_acc_pkg.sv
// Shared definitions for the streaming dot-product controller and the
// pipelined 8x8 multiplier it feeds.
//   - state_t             : controller FSM states
//   - OP_W / PROD_W       : operand and product widths of the multiplier
//   - DEFAULT_MUL_LATENCY : multiplier pipeline depth; both the multiplier
//                           and this controller default to this one value
package dot_product_acc_pkg;

  localparam int OP_W                = 8;
  localparam int PROD_W              = 16;
  localparam int DEFAULT_MUL_LATENCY = 5;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit shift register that tracks "a real operand pair entered the
// multiplier" through its fixed pipeline latency.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset, clears every stage
//   din     : tag shifted in this cycle
//   dout    : tag that entered DEPTH edges ago
//   pending : high while any stage holds a 1 (tags in flight)
module valid_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic pending
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout    = stages[DEPTH-1];
  assign pending = |stages;

endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product controller. Accepts operand pairs, forwards them to
// an external pipelined multiplier, accumulates the returning products and
// presents the sum once VEC_LEN products have retired.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The source must hold in_valid/in_a/in_b until accepted; out_acc/out_ovf
// stay stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : operand-pair handshake, in_a/in_b operands
//   mul_a/mul_b       : operands to multiplier (zero when nothing accepted)
//   mul_product       : multiplier result, MUL_LATENCY edges after mul_a/b
//   out_valid/out_ready, out_acc, out_ovf : result handshake and payload
//   busy              : not in ACCEPT, or products still in flight
//   state             : current FSM state for observation
module dot_product_acc
  import dot_product_acc_pkg::*;
#(
  parameter int VEC_LEN     = 8,
  parameter int ACC_W       = 24,
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             accept;
  logic             retire;
  logic             tags_pending;
  logic             consume;
  logic [ACC_W:0]   acc_sum;

  // Derived from the state register directly so accept does not loop
  // through the FSM output logic.
  assign accept  = in_valid && (st == ACCEPT);
  assign consume = (st == HOLD) && out_ready;

  valid_delay_line #(.DEPTH(MUL_LATENCY)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .din     (accept),
    .dout    (retire),
    .pending (tags_pending)
  );

  // Extra top bit captures the carry-out that sets the sticky overflow.
  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(mul_product);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ACCEPT;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st)
      ACCEPT: begin
        in_ready = 1'b1;
        if (accept && (acc_cnt == LAST)) st_nxt = DRAIN;
      end
      DRAIN: begin
        if (retire && (ret_cnt == LAST)) st_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = ACCEPT;
      end
      default: st_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      acc_cnt <= '0;
      ret_cnt <= '0;
    end else if (consume) begin
      acc     <= '0;
      ovf     <= 1'b0;
      acc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      // Accepts and retirements can coincide in ACCEPT; both update.
      if (accept) acc_cnt <= acc_cnt + 1'b1;
      if (retire) begin
        acc     <= acc_sum[ACC_W-1:0];
        ret_cnt <= ret_cnt + 1'b1;
        if (acc_sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  assign mul_a   = accept ? in_a : '0;
  assign mul_b   = accept ? in_b : '0;
  assign out_acc = (st == HOLD) ? acc : '0;
  assign out_ovf = ovf;
  assign busy    = (st != ACCEPT) || tags_pending;
  assign state   = st;

endmodule

// File: tb/tb_dot_product_acc.sv
// Bench for dot_product_acc. Two instances share all stimulus: one with the
// default 24-bit accumulator and one with a 16-bit accumulator so wrap and
// sticky-overflow behaviour is exercised on every vector. Each instance has
// its own behavioural 5-stage multiplier.
module tb_dot_product_acc;

  localparam int VEC_LEN = 8;
  localparam int MUL_LAT = 5;
  localparam int W0      = 24;
  localparam int W1      = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [7:0]  m0_a, m0_b, m1_a, m1_b;
  logic [15:0] prod0, prod1;
  logic        out_valid0, out_valid1;
  logic [W0-1:0] out_acc0;
  logic [W1-1:0] out_acc1;
  logic        out_ovf0, out_ovf1;
  logic        busy0, busy1;
  logic [1:0]  state0, state1;

  int checks = 0;
  int errors = 0;

  logic [W0-1:0] exp_q0[$];
  logic [W1-1:0] exp_q1[$];
  logic          exp_ovf_q0[$];
  logic          exp_ovf_q1[$];

  dot_product_acc #(.VEC_LEN(VEC_LEN), .ACC_W(W0), .MUL_LATENCY(MUL_LAT)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .mul_a(m0_a), .mul_b(m0_b),
    .mul_product(prod0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_acc(out_acc0), .out_ovf(out_ovf0), .busy(busy0), .state(state0)
  );

  dot_product_acc #(.VEC_LEN(VEC_LEN), .ACC_W(W1), .MUL_LATENCY(MUL_LAT)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .mul_a(m1_a), .mul_b(m1_b),
    .mul_product(prod1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_acc(out_acc1), .out_ovf(out_ovf1), .busy(busy1), .state(state1)
  );

  // ---------------- clock / multiplier models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pipe0[MUL_LAT];
  logic [15:0] pipe1[MUL_LAT];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe0[i] <= '0;
        pipe1[i] <= '0;
      end
    end else begin
      pipe0[0] <= 16'(m0_a) * 16'(m0_b);
      pipe1[0] <= 16'(m1_a) * 16'(m1_b);
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe0[i] <= pipe0[i-1];
        pipe1[i] <= pipe1[i-1];
      end
    end
  end

  assign prod0 = pipe0[MUL_LAT-1];
  assign prod1 = pipe1[MUL_LAT-1];

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] a_vec;
    logic [63:0] b_vec;
    int          max_gap;
    int          hold;
    logic [31:0] sum;
  } vec_t;

  vec_t tbl[5];

  // Scoreboard push: reduce the full-precision sum to each accumulator width.
  task automatic push_expect(input logic [31:0] sum);
    exp_q0.push_back(sum[W0-1:0]);
    exp_ovf_q0.push_back(sum >= 32'(1 << W0));
    exp_q1.push_back(sum[W1-1:0]);
    exp_ovf_q1.push_back(sum >= 32'(1 << W1));
  endtask

  // ---------------- driver ----------------
  // Sends eight pairs with optional 1..max_gap idle cycles between them.
  // Returns just after the edge that accepted the last pair, leaving junk
  // operands presented so the DRAIN-state ignore path is observed.
  task automatic send_pairs(input logic [63:0] av, input logic [63:0] bv, input int max_gap);
    for (int i = 0; i < VEC_LEN; i++) begin
      if (i > 0 && max_gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_a = av[i*8 +: 8];
      in_b = bv[i*8 +: 8];
      @(negedge clk);
      chk("in_ready_accept", 32'(in_ready0), 32'd1);
      chk("mul_a_pass", 32'(m0_a), 32'(in_a));
      chk("mul_b_pass", 32'(m1_b), 32'(in_b));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
  endtask

  // Waits for the result, checks latency and payload, optionally stalls
  // the consumer for `hold` cycles, then completes the output handshake.
  task automatic wait_result(input int hold);
    int k;
    logic [W0-1:0] e0;
    logic [W1-1:0] e1;
    k = 0;
    forever begin
      @(negedge clk);
      if (k == 0) begin
        chk("drain_in_ready", 32'(in_ready0), 32'd0);
        chk("drain_mul_a_zero", 32'(m0_a), 32'd0);
        chk("drain_busy", 32'(busy0), 32'd1);
      end
      if (out_valid0 || k > 100) break;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k++;
    end
    in_valid = 1'b0;
    if (k > 100) begin
      chk("result_timeout", 32'(out_valid0), 32'd1);
      return;
    end
    chk("latency", 32'(k + 1), 32'(MUL_LAT + 1));
    chk("out_valid16", 32'(out_valid1), 32'd1);
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    chk("out_acc24", 32'(out_acc0), 32'(e0));
    chk("out_ovf24", 32'(out_ovf0), 32'(exp_ovf_q0.pop_front()));
    chk("out_acc16", 32'(out_acc1), 32'(e1));
    chk("out_ovf16", 32'(out_ovf1), 32'(exp_ovf_q1.pop_front()));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid0), 32'd1);
      chk("hold_acc", 32'(out_acc0), 32'(e0));
      chk("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready0), 32'd1);
    chk("post_out_valid", 32'(out_valid0), 32'd0);
    chk("post_busy", 32'(busy0), 32'd0);
  endtask

  task automatic run_vector(input logic [63:0] av, input logic [63:0] bv,
                            input int max_gap, input int hold, input logic [31:0] sum);
    push_expect(sum);
    send_pairs(av, bv, max_gap);
    wait_result(hold);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [63:0] ramp, twos, ffs, ones, threes, ra, rb;
    logic [31:0] rsum;

    for (int i = 0; i < 8; i++) begin
      ramp[i*8 +: 8]   = 8'(i + 1);
      twos[i*8 +: 8]   = 8'd2;
      ffs[i*8 +: 8]    = 8'd255;
      ones[i*8 +: 8]   = 8'd1;
      threes[i*8 +: 8] = 8'd3;
    end
    tbl[0] = '{a_vec: ramp, b_vec: twos, max_gap: 0, hold: 0,  sum: 32'd72};
    tbl[1] = '{a_vec: ffs,  b_vec: ffs,  max_gap: 0, hold: 0,  sum: 32'd520200};
    tbl[2] = '{a_vec: ramp, b_vec: twos, max_gap: 3, hold: 0,  sum: 32'd72};
    tbl[3] = '{a_vec: ramp, b_vec: twos, max_gap: 0, hold: 10, sum: 32'd72};
    tbl[4] = '{a_vec: ones, b_vec: ones, max_gap: 0, hold: 0,  sum: 32'd8};

    rst = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h12;
    in_b = 8'h34;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_acc", 32'(out_acc0), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_mul_a", 32'(m0_a), 32'd0);
    chk("rst_mul_b", 32'(m0_b), 32'd0);
    chk("rst_state", 32'(state0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      run_vector(tbl[t].a_vec, tbl[t].b_vec, tbl[t].max_gap, tbl[t].hold, tbl[t].sum);
    end

    // Reset in the middle of DRAIN (cycle 10 counting the first pair as 0).
    send_pairs(ramp, twos, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy0), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid0), 32'd0);
    chk("midrst_in_ready", 32'(in_ready0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ovf16", 32'(out_ovf1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vector(threes, threes, 0, 0, 32'd72);

    // Random operands and gaps, expectation from a reference sum.
    for (int r = 0; r < 3; r++) begin
      rsum = '0;
      for (int i = 0; i < 8; i++) begin
        ra[i*8 +: 8] = 8'($urandom_range(0, 255));
        rb[i*8 +: 8] = 8'($urandom_range(0, 255));
        rsum += 32'(ra[i*8 +: 8]) * 32'(rb[i*8 +: 8]);
      end
      run_vector(ra, rb, r, r, rsum);
    end

    chk("queue_empty", 32'(exp_q0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
